// File: rtl/ptp_pkg.sv
// Shared constants for the peer-delay responder: FSM state encodings, PTP message types
// and default field widths.
package ptp_pkg;

    localparam int TIMESTAMP_W        = 80;
    localparam int SEQID_W            = 16;
    localparam int PORTID_W           = 80;
    localparam int TS_TIMEOUT_DEFAULT = 2500;

    localparam logic [3:0] MSG_PDELAY_RESP    = 4'h3;
    localparam logic [3:0] MSG_PDELAY_RESP_FU = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_RESP = 3'd1,
        ST_WAIT_TS   = 3'd2,
        ST_SEND_FU   = 3'd3,
        ST_DONE      = 3'd4
    } pdelay_state_e;

endpackage

// File: rtl/ptp_pdelay_req_slot.sv
// One-entry holding slot for a Pdelay_Req that arrives while an exchange is running.
// Only built when PTP_PDELAY_RESP_PENDING_EN is defined; a newer push replaces the stored entry.
`ifdef PTP_PDELAY_RESP_PENDING_EN
module ptp_pdelay_req_slot
    import ptp_pkg::*;
#(
    parameter int TIMESTAMP_WIDTH = TIMESTAMP_W,
    parameter int SEQID_WIDTH     = SEQID_W,
    parameter int PORTID_WIDTH    = PORTID_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       push_twostep,
    input  logic [SEQID_WIDTH-1:0]     push_seqid,
    input  logic [PORTID_WIDTH-1:0]    push_portid,
    input  logic [TIMESTAMP_WIDTH-1:0] push_ts,
    input  logic                       pop,
    output logic                       slot_valid,
    output logic                       slot_twostep,
    output logic [SEQID_WIDTH-1:0]     slot_seqid,
    output logic [PORTID_WIDTH-1:0]    slot_portid,
    output logic [TIMESTAMP_WIDTH-1:0] slot_ts
);

    // Push beats pop so a request landing in the consume cycle is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid   <= 1'b0;
            slot_twostep <= 1'b0;
            slot_seqid   <= '0;
            slot_portid  <= '0;
            slot_ts      <= '0;
        end else if (push) begin
            slot_valid   <= 1'b1;
            slot_twostep <= push_twostep;
            slot_seqid   <= push_seqid;
            slot_portid  <= push_portid;
            slot_ts      <= push_ts;
        end else if (pop) begin
            slot_valid   <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/ptp_pdelay_responder.sv
// 802.1AS peer-delay responder: answers a parsed Pdelay_Req with Pdelay_Resp and, in two-step
// mode, Pdelay_Resp_Follow_Up carrying t3. Optional pending slot: PTP_PDELAY_RESP_PENDING_EN.
module ptp_pdelay_responder
    import ptp_pkg::*;
#(
    parameter int TIMESTAMP_WIDTH = TIMESTAMP_W,
    parameter int SEQID_WIDTH     = SEQID_W,
    parameter int PORTID_WIDTH    = PORTID_W,
    parameter int TS_TIMEOUT_CYC  = TS_TIMEOUT_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_twostep,
    input  logic                       i_req_valid,
    input  logic [SEQID_WIDTH-1:0]     i_req_seqid,
    input  logic [PORTID_WIDTH-1:0]    i_req_portid,
    input  logic [TIMESTAMP_WIDTH-1:0] i_req_rx_ts,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic [3:0]                 o_tx_msg_type,
    output logic [SEQID_WIDTH-1:0]     o_tx_seqid,
    output logic [PORTID_WIDTH-1:0]    o_tx_portid,
    output logic [TIMESTAMP_WIDTH-1:0] o_tx_ts,
    input  logic                       i_tx_ts_valid,
    input  logic [TIMESTAMP_WIDTH-1:0] i_tx_ts,
    output logic                       o_resp_start,
    output logic                       o_resp_send_end,
    output logic                       o_respfw_send_end,
    output logic                       o_resp_end,
    output logic                       o_ts_timeout,
    output logic                       o_busy,
    output logic [7:0]                 o_state,
    output logic [15:0]                o_drop_cnt
);

    // TX handshake: o_tx_valid rises with a complete payload, which stays frozen until the
    // cycle o_tx_valid && i_tx_ready is seen; the message is then consumed and valid drops.

    localparam int TIMER_W = $clog2(TS_TIMEOUT_CYC + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TS_TIMEOUT_CYC - 1);

    pdelay_state_e              state;
    logic [TIMER_W-1:0]         timer;
    logic                       twostep_q;

    logic                       start_req;
    logic                       start_twostep;
    logic [SEQID_WIDTH-1:0]     start_seqid;
    logic [PORTID_WIDTH-1:0]    start_portid;
    logic [TIMESTAMP_WIDTH-1:0] start_ts;
    logic                       drop_event;

    assign o_state = {5'd0, state};

`ifdef PTP_PDELAY_RESP_PENDING_EN
    logic                       slot_push;
    logic                       slot_pop;
    logic                       slot_valid;
    logic                       slot_twostep;
    logic [SEQID_WIDTH-1:0]     slot_seqid;
    logic [PORTID_WIDTH-1:0]    slot_portid;
    logic [TIMESTAMP_WIDTH-1:0] slot_ts;

    // In DONE with an empty slot the new request launches directly instead of parking.
    assign slot_push  = i_req_valid && (state != ST_IDLE) && !(state == ST_DONE && !slot_valid);
    assign slot_pop   = (state == ST_DONE) && slot_valid;
    assign drop_event = slot_push && slot_valid && !slot_pop;

    ptp_pdelay_req_slot #(
        .TIMESTAMP_WIDTH (TIMESTAMP_WIDTH),
        .SEQID_WIDTH     (SEQID_WIDTH),
        .PORTID_WIDTH    (PORTID_WIDTH)
    ) u_req_slot (
        .clk          (i_clk),
        .rst_n        (i_rst),
        .push         (slot_push),
        .push_twostep (i_twostep),
        .push_seqid   (i_req_seqid),
        .push_portid  (i_req_portid),
        .push_ts      (i_req_rx_ts),
        .pop          (slot_pop),
        .slot_valid   (slot_valid),
        .slot_twostep (slot_twostep),
        .slot_seqid   (slot_seqid),
        .slot_portid  (slot_portid),
        .slot_ts      (slot_ts)
    );
`else
    assign drop_event = i_req_valid && (state != ST_IDLE);
`endif

    always_comb begin
        start_req     = 1'b0;
        start_twostep = i_twostep;
        start_seqid   = i_req_seqid;
        start_portid  = i_req_portid;
        start_ts      = i_req_rx_ts;
        if (state == ST_IDLE && i_req_valid) begin
            start_req = 1'b1;
        end
`ifdef PTP_PDELAY_RESP_PENDING_EN
        if (state == ST_DONE) begin
            if (slot_valid) begin
                start_req     = 1'b1;
                start_twostep = slot_twostep;
                start_seqid   = slot_seqid;
                start_portid  = slot_portid;
                start_ts      = slot_ts;
            end else if (i_req_valid) begin
                start_req = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state             <= ST_IDLE;
            timer             <= '0;
            twostep_q         <= 1'b0;
            o_tx_valid        <= 1'b0;
            o_tx_msg_type     <= 4'h0;
            o_tx_seqid        <= '0;
            o_tx_portid       <= '0;
            o_tx_ts           <= '0;
            o_resp_start      <= 1'b0;
            o_resp_send_end   <= 1'b0;
            o_respfw_send_end <= 1'b0;
            o_resp_end        <= 1'b0;
            o_ts_timeout      <= 1'b0;
            o_busy            <= 1'b0;
        end else begin
            o_resp_start      <= 1'b0;
            o_resp_send_end   <= 1'b0;
            o_respfw_send_end <= 1'b0;
            o_resp_end        <= 1'b0;
            o_ts_timeout      <= 1'b0;
            case (state)
                ST_IDLE: ;
                ST_SEND_RESP: begin
                    if (i_tx_ready) begin
                        o_tx_valid      <= 1'b0;
                        o_resp_send_end <= 1'b1;
                        timer           <= '0;
                        state           <= twostep_q ? ST_WAIT_TS : ST_DONE;
                    end
                end
                ST_WAIT_TS: begin
                    // A timestamp arriving on the last timeout cycle still wins.
                    if (i_tx_ts_valid) begin
                        o_tx_ts       <= i_tx_ts;
                        o_tx_msg_type <= MSG_PDELAY_RESP_FU;
                        o_tx_valid    <= 1'b1;
                        state         <= ST_SEND_FU;
                    end else if (timer == TIMEOUT_LAST) begin
                        o_ts_timeout <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_SEND_FU: begin
                    if (i_tx_ready) begin
                        o_tx_valid        <= 1'b0;
                        o_respfw_send_end <= 1'b1;
                        state             <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_resp_end <= 1'b1;
                    o_busy     <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    o_tx_valid <= 1'b0;
                    o_busy     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
            // One-step Resp carries zero; the MAC inserts the turnaround correction.
            if (start_req) begin
                state         <= ST_SEND_RESP;
                o_busy        <= 1'b1;
                o_resp_start  <= 1'b1;
                o_tx_valid    <= 1'b1;
                o_tx_msg_type <= MSG_PDELAY_RESP;
                o_tx_seqid    <= start_seqid;
                o_tx_portid   <= start_portid;
                o_tx_ts       <= start_twostep ? start_ts : '0;
                twostep_q     <= start_twostep;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_drop_cnt <= 16'd0;
        end else if (drop_event && o_drop_cnt != 16'hFFFF) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ptp_pdelay_responder.sv
// Directed bench for ptp_pdelay_responder: two-step, one-step, backpressure, t3 timeout,
// overlapping request (both PTP_PDELAY_RESP_PENDING_EN builds) and reset mid-exchange.
module tb_ptp_pdelay_responder;

    localparam logic [79:0] PID_A = 80'h0011_2233_4455_6677_0001;
    localparam logic [79:0] PID_B = 80'h8899_AABB_CCDD_EEFF_0002;
    localparam logic [79:0] T2_A  = 80'h0000_0000_1234_0000_0100;
    localparam logic [79:0] T2_B  = 80'h0000_0000_5678_0000_0200;
    localparam logic [79:0] T3_A  = 80'h0000_0000_1234_0000_0900;
    localparam logic [79:0] T3_B  = 80'h0000_0000_5678_0000_0A00;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_twostep = 1'b0;
    logic        i_req_valid = 1'b0;
    logic [15:0] i_req_seqid = '0;
    logic [79:0] i_req_portid = '0;
    logic [79:0] i_req_rx_ts = '0;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic [3:0]  o_tx_msg_type;
    logic [15:0] o_tx_seqid;
    logic [79:0] o_tx_portid;
    logic [79:0] o_tx_ts;
    logic        i_tx_ts_valid = 1'b0;
    logic [79:0] i_tx_ts = '0;
    logic        o_resp_start;
    logic        o_resp_send_end;
    logic        o_respfw_send_end;
    logic        o_resp_end;
    logic        o_ts_timeout;
    logic        o_busy;
    logic [7:0]  o_state;
    logic [15:0] o_drop_cnt;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int resp_end_cnt = 0;
    int wait_cycles = 0;

    always #2 i_clk = ~i_clk;

    ptp_pdelay_responder dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_twostep         (i_twostep),
        .i_req_valid       (i_req_valid),
        .i_req_seqid       (i_req_seqid),
        .i_req_portid      (i_req_portid),
        .i_req_rx_ts       (i_req_rx_ts),
        .o_tx_valid        (o_tx_valid),
        .i_tx_ready        (i_tx_ready),
        .o_tx_msg_type     (o_tx_msg_type),
        .o_tx_seqid        (o_tx_seqid),
        .o_tx_portid       (o_tx_portid),
        .o_tx_ts           (o_tx_ts),
        .i_tx_ts_valid     (i_tx_ts_valid),
        .i_tx_ts           (i_tx_ts),
        .o_resp_start      (o_resp_start),
        .o_resp_send_end   (o_resp_send_end),
        .o_respfw_send_end (o_respfw_send_end),
        .o_resp_end        (o_resp_end),
        .o_ts_timeout      (o_ts_timeout),
        .o_busy            (o_busy),
        .o_state           (o_state),
        .o_drop_cnt        (o_drop_cnt)
    );

    // Event monitors: sample pre-edge values, i.e. what the DUT showed during the last cycle.
    always @(posedge i_clk) begin
        if (o_tx_valid && i_tx_ready) hs_cnt++;
        if (o_resp_end) resp_end_cnt++;
        if (o_state == 8'd2) wait_cycles++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_req(input logic [15:0] seq, input logic [79:0] pid,
                          input logic [79:0] ts, input logic twostep);
        @(negedge i_clk);
        i_req_valid  = 1'b1;
        i_req_seqid  = seq;
        i_req_portid = pid;
        i_req_rx_ts  = ts;
        i_twostep    = twostep;
        @(negedge i_clk);
        i_req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_tx_valid, o_resp_start, o_resp_send_end, o_respfw_send_end, o_resp_end,
             o_ts_timeout, o_busy} !== 7'd0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0", {o_tx_valid, o_resp_start,
                     o_resp_send_end, o_respfw_send_end, o_resp_end, o_ts_timeout, o_busy});
        end
        checks++;
        if (o_state !== 8'd0 || o_drop_cnt !== 16'd0 || o_tx_ts !== 80'd0 || o_tx_msg_type !== 4'd0) begin
            errors++;
            $display("FAIL reset_values: state %0d drop %0d ts %h type %h, expected all 0",
                     o_state, o_drop_cnt, o_tx_ts, o_tx_msg_type);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_two_step();
        int re0 = resp_end_cnt;
        int hs0 = hs_cnt;
        i_tx_ready = 1'b1;
        do_req(16'h0012, PID_A, T2_A, 1'b1);
        checks++;
        if (o_resp_start !== 1'b1 || o_tx_valid !== 1'b1 || o_busy !== 1'b1 || o_state !== 8'd1) begin
            errors++;
            $display("FAIL twostep_start: start %b valid %b busy %b state %0d expected 1 1 1 1",
                     o_resp_start, o_tx_valid, o_busy, o_state);
        end
        checks++;
        if (o_tx_msg_type !== 4'h3 || o_tx_seqid !== 16'h0012 || o_tx_portid !== PID_A || o_tx_ts !== T2_A) begin
            errors++;
            $display("FAIL twostep_resp_payload: type %h seq %h pid %h ts %h expected 3 0012 %h %h",
                     o_tx_msg_type, o_tx_seqid, o_tx_portid, o_tx_ts, PID_A, T2_A);
        end
        @(negedge i_clk);
        checks++;
        if (o_resp_send_end !== 1'b1 || o_tx_valid !== 1'b0 || o_state !== 8'd2) begin
            errors++;
            $display("FAIL twostep_send_end: send_end %b valid %b state %0d expected 1 0 2",
                     o_resp_send_end, o_tx_valid, o_state);
        end
        repeat (39) @(negedge i_clk);
        i_tx_ts_valid = 1'b1;
        i_tx_ts       = T3_A;
        @(negedge i_clk);
        i_tx_ts_valid = 1'b0;
        checks++;
        if (o_state !== 8'd3 || o_tx_valid !== 1'b1 || o_tx_msg_type !== 4'hA ||
            o_tx_ts !== T3_A || o_tx_seqid !== 16'h0012 || o_tx_portid !== PID_A) begin
            errors++;
            $display("FAIL twostep_fu_payload: state %0d valid %b type %h ts %h seq %h expected 3 1 A %h 0012",
                     o_state, o_tx_valid, o_tx_msg_type, o_tx_ts, o_tx_seqid, T3_A);
        end
        @(negedge i_clk);
        checks++;
        if (o_respfw_send_end !== 1'b1 || o_state !== 8'd4 || o_tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL twostep_fu_end: fw_end %b state %0d valid %b expected 1 4 0",
                     o_respfw_send_end, o_state, o_tx_valid);
        end
        @(negedge i_clk);
        checks++;
        if (o_resp_end !== 1'b1 || o_state !== 8'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL twostep_resp_end: end %b state %0d busy %b expected 1 0 0",
                     o_resp_end, o_state, o_busy);
        end
        repeat (3) @(negedge i_clk);
        checks++;
        if (resp_end_cnt - re0 !== 1 || hs_cnt - hs0 !== 2) begin
            errors++;
            $display("FAIL twostep_counts: resp_end %0d handshakes %0d expected 1 2",
                     resp_end_cnt - re0, hs_cnt - hs0);
        end
    endtask

    task automatic test_one_step();
        int hs0 = hs_cnt;
        int wc0 = wait_cycles;
        i_tx_ready = 1'b1;
        do_req(16'h0055, PID_B, T2_B, 1'b0);
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_msg_type !== 4'h3 || o_tx_seqid !== 16'h0055 ||
            o_tx_portid !== PID_B || o_tx_ts !== 80'd0) begin
            errors++;
            $display("FAIL onestep_resp_payload: valid %b type %h seq %h ts %h expected 1 3 0055 0",
                     o_tx_valid, o_tx_msg_type, o_tx_seqid, o_tx_ts);
        end
        @(negedge i_clk);
        checks++;
        if (o_resp_send_end !== 1'b1 || o_state !== 8'd4) begin
            errors++;
            $display("FAIL onestep_send_end: send_end %b state %0d expected 1 4", o_resp_send_end, o_state);
        end
        @(negedge i_clk);
        checks++;
        if (o_resp_end !== 1'b1 || o_state !== 8'd0) begin
            errors++;
            $display("FAIL onestep_resp_end: end %b state %0d expected 1 0", o_resp_end, o_state);
        end
        repeat (5) @(negedge i_clk);
        checks++;
        if (hs_cnt - hs0 !== 1 || wait_cycles - wc0 !== 0) begin
            errors++;
            $display("FAIL onestep_no_fu: handshakes %0d wait_ts cycles %0d expected 1 0",
                     hs_cnt - hs0, wait_cycles - wc0);
        end
    endtask

    task automatic test_backpressure();
        int hs0 = hs_cnt;
        bit stable = 1'b1;
        i_tx_ready = 1'b0;
        do_req(16'h0077, PID_A, T2_B, 1'b0);
        repeat (20) begin
            if (!(o_tx_valid === 1'b1 && o_tx_msg_type === 4'h3 && o_tx_seqid === 16'h0077 &&
                  o_tx_portid === PID_A && o_tx_ts === 80'd0 && o_state === 8'd1)) stable = 1'b0;
            @(negedge i_clk);
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_hold: got unstable valid/payload expected held for 20 cycles");
        end
        i_tx_ready = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_resp_send_end !== 1'b1 || o_tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: send_end %b valid %b expected 1 0", o_resp_send_end, o_tx_valid);
        end
        repeat (3) @(negedge i_clk);
        checks++;
        if (hs_cnt - hs0 !== 1) begin
            errors++;
            $display("FAIL backpressure_handshakes: got %0d expected 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_timeout();
        int hs0 = hs_cnt;
        int n = 0;
        i_tx_ready = 1'b1;
        do_req(16'h0100, PID_B, T2_A, 1'b1);
        @(negedge i_clk);
        checks++;
        if (o_state !== 8'd2) begin
            errors++;
            $display("FAIL timeout_enter_wait: state %0d expected 2", o_state);
        end
        while (o_ts_timeout !== 1'b1 && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_ts_timeout !== 1'b1 || n !== 2500) begin
            errors++;
            $display("FAIL timeout_cycle: pulse %b after %0d cycles expected 1 after 2500", o_ts_timeout, n);
        end
        @(negedge i_clk);
        checks++;
        if (o_resp_end !== 1'b1 || o_busy !== 1'b0 || o_state !== 8'd0) begin
            errors++;
            $display("FAIL timeout_end: end %b busy %b state %0d expected 1 0 0", o_resp_end, o_busy, o_state);
        end
        repeat (3) @(negedge i_clk);
        checks++;
        if (hs_cnt - hs0 !== 1) begin
            errors++;
            $display("FAIL timeout_no_fu: handshakes %0d expected 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_overlap();
        int hs0 = hs_cnt;
        i_tx_ready = 1'b1;
        do_req(16'h0200, PID_A, T2_A, 1'b1);
        @(negedge i_clk);
        do_req(16'h0201, PID_B, T2_B, 1'b1);
        i_tx_ts_valid = 1'b1;
        i_tx_ts       = T3_A;
        @(negedge i_clk);
        i_tx_ts_valid = 1'b0;
        checks++;
        if (o_tx_msg_type !== 4'hA || o_tx_seqid !== 16'h0200 || o_tx_ts !== T3_A) begin
            errors++;
            $display("FAIL overlap_first_fu: type %h seq %h ts %h expected A 0200 %h",
                     o_tx_msg_type, o_tx_seqid, o_tx_ts, T3_A);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_resp_end !== 1'b1) begin
            errors++;
            $display("FAIL overlap_first_end: end %b expected 1", o_resp_end);
        end
`ifdef PTP_PDELAY_RESP_PENDING_EN
        checks++;
        if (o_state !== 8'd1 || o_resp_start !== 1'b1 || o_tx_valid !== 1'b1 ||
            o_tx_seqid !== 16'h0201 || o_tx_portid !== PID_B || o_tx_ts !== T2_B || o_drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL overlap_pending_resp: state %0d start %b seq %h ts %h drop %0d expected 1 1 0201 %h 0",
                     o_state, o_resp_start, o_tx_seqid, o_tx_ts, o_drop_cnt, T2_B);
        end
        @(negedge i_clk);
        i_tx_ts_valid = 1'b1;
        i_tx_ts       = T3_B;
        @(negedge i_clk);
        i_tx_ts_valid = 1'b0;
        checks++;
        if (o_tx_msg_type !== 4'hA || o_tx_seqid !== 16'h0201 || o_tx_ts !== T3_B) begin
            errors++;
            $display("FAIL overlap_pending_fu: type %h seq %h ts %h expected A 0201 %h",
                     o_tx_msg_type, o_tx_seqid, o_tx_ts, T3_B);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        repeat (3) @(negedge i_clk);
        checks++;
        if (hs_cnt - hs0 !== 4 || o_state !== 8'd0) begin
            errors++;
            $display("FAIL overlap_pending_total: handshakes %0d state %0d expected 4 0", hs_cnt - hs0, o_state);
        end
`else
        checks++;
        if (o_drop_cnt !== 16'd1 || o_state !== 8'd0) begin
            errors++;
            $display("FAIL overlap_drop: drop %0d state %0d expected 1 0", o_drop_cnt, o_state);
        end
        repeat (5) @(negedge i_clk);
        checks++;
        if (hs_cnt - hs0 !== 2 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL overlap_no_second: handshakes %0d busy %b expected 2 0", hs_cnt - hs0, o_busy);
        end
`endif
    endtask

    task automatic test_reset_mid();
        i_tx_ready = 1'b1;
        do_req(16'h0300, PID_A, T2_A, 1'b1);
        @(negedge i_clk);
        i_tx_ready    = 1'b0;
        i_tx_ts_valid = 1'b1;
        i_tx_ts       = T3_B;
        @(negedge i_clk);
        i_tx_ts_valid = 1'b0;
        checks++;
        if (o_state !== 8'd3 || o_tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_in_fu: state %0d valid %b expected 3 1", o_state, o_tx_valid);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_state !== 8'd0 || o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_tx_ts !== 80'd0 ||
            o_drop_cnt !== 16'd0 || o_respfw_send_end !== 1'b0 || o_tx_seqid !== 16'd0) begin
            errors++;
            $display("FAIL resetmid_outputs: state %0d valid %b busy %b ts %h drop %0d expected all 0",
                     o_state, o_tx_valid, o_busy, o_tx_ts, o_drop_cnt);
        end
        i_rst      = 1'b1;
        i_tx_ready = 1'b1;
        do_req(16'h0301, PID_B, T2_B, 1'b0);
        checks++;
        if (o_resp_start !== 1'b1 || o_tx_msg_type !== 4'h3 || o_tx_seqid !== 16'h0301 || o_tx_ts !== 80'd0) begin
            errors++;
            $display("FAIL resetmid_fresh_resp: start %b type %h seq %h ts %h expected 1 3 0301 0",
                     o_resp_start, o_tx_msg_type, o_tx_seqid, o_tx_ts);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_resp_end !== 1'b1 || o_state !== 8'd0) begin
            errors++;
            $display("FAIL resetmid_fresh_end: end %b state %0d expected 1 0", o_resp_end, o_state);
        end
    endtask

    initial begin
        test_reset();
        test_two_step();
        test_one_step();
        test_backpressure();
        test_timeout();
        test_overlap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
